// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the IMemory PC and buffers {pc, instr} pairs for decode in a 2-entry queue.
// Optional IMEM_MISALIGN_TRAP_EN: a misaligned redirect halts fetch and raises a sticky fault instead of being word-aligned.
module imem_fetch_ctrl #(
  parameter int unsigned       ISIZE     = 32,
  parameter logic [31:0]       RESET_PC  = 32'h0000_0000,
  parameter logic [ISIZE-1:0]  HALT_WORD = '1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [31:0]       imem_pc,
  input  logic [ISIZE-1:0]  imem_instr,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  output logic [ISIZE-1:0]  out_instr,
  output logic [31:0]       out_pc,
  input  logic              out_ready,
  output logic              busy,
  output logic              halted,
  output logic              fault
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [ISIZE-1:0]  q_instr_q [2];
  logic [ISIZE-1:0]  q_instr_d [2];
  logic [31:0]       q_pc_q [2];
  logic [31:0]       q_pc_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [ISIZE-1:0]  out_instr_q, out_instr_d;
  logic [31:0]       out_pc_q, out_pc_d;
  logic              fault_q, fault_d;
  logic              push, pop, misalign;

  always_comb begin
    pop  = out_valid_q && out_ready;
    push = (state_q == RUN) && ((cnt_q != 2'd2) || pop);
`ifdef IMEM_MISALIGN_TRAP_EN
    misalign = (redirect_pc[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif

    state_d   = state_q;
    pc_d      = pc_q;
    q_instr_d = q_instr_q;
    q_pc_d    = q_pc_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    fault_d   = fault_q;

    // Redirect wins outright: the same-cycle push and pop are both dropped.
    if (redirect_valid) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      cnt_d    = 2'd0;
      if (misalign) begin
        state_d = HALT;
        fault_d = 1'b1;
      end else begin
        state_d = RUN;
        pc_d    = redirect_pc & ~32'h3;
      end
    end else begin
      if (state_q == IDLE && start) begin
        state_d = RUN;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      if (push) begin
        q_pc_d[wr_ptr_q]    = pc_q;
        q_instr_d[wr_ptr_q] = imem_instr;
        wr_ptr_d            = ~wr_ptr_q;
        pc_d                = pc_q + 32'd4;
        if (imem_instr == HALT_WORD) begin
          state_d = HALT;
        end
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    // Output registers track the next queue head and hold when it empties.
    out_valid_d = (cnt_d != 2'd0);
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    if (cnt_d != 2'd0) begin
      out_pc_d    = q_pc_d[rd_ptr_d];
      out_instr_d = q_instr_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      for (int unsigned i = 0; i < 2; i++) begin
        q_instr_q[i] <= '0;
        q_pc_q[i]    <= '0;
      end
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      q_instr_q   <= q_instr_d;
      q_pc_q      <= q_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      fault_q     <= fault_d;
    end
  end

  assign imem_pc   = pc_q;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign busy      = (state_q == RUN);
  assign halted    = (state_q == HALT);
  assign fault     = fault_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: expected {pc, instr} pushed with stimulus, compared against accepted handshakes.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n, start, redirect_valid, out_ready;
  logic [31:0] imem_pc, redirect_pc, out_pc;
  logic [31:0] imem_instr, out_instr;
  logic        out_valid, busy, halted, fault;

  logic        halt_en;
  logic [31:0] halt_addr;
  logic [63:0] exp_q [$];
  logic [63:0] obs_q [$];
  logic [63:0] e, o;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .ISIZE    (32),
    .RESET_PC (32'h0000_0000),
    .HALT_WORD(32'hFFFF_FFFF)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .imem_pc       (imem_pc),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_ready     (out_ready),
    .busy          (busy),
    .halted        (halted),
    .fault         (fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (halt_en && a == halt_addr) return 32'hFFFF_FFFF;
    return a ^ 32'hA500_0013;
  endfunction

  assign imem_instr = mem_word(imem_pc);

  function automatic logic [63:0] ent(input logic [31:0] a);
    return {a, mem_word(a)};
  endfunction

  // Sample the handshake of the current cycle, then step to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (reset_n && out_valid && out_ready && !redirect_valid)
      obs_q.push_back({out_pc, out_instr});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    out_ready = 1'b0; halt_en = 1'b0; halt_addr = '0;
    exp_q.delete(); obs_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    reset_n = 1'b0;
    #2;
    vectors++;
    if (imem_pc !== 32'h0 || out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0 ||
        busy !== 1'b0 || halted !== 1'b0 || fault !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values got pc=%h v=%b instr=%h opc=%h busy=%b halted=%b fault=%b want all zero",
               imem_pc, out_valid, out_instr, out_pc, busy, halted, fault);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back(ent(32'h0)); exp_q.push_back(ent(32'h4)); exp_q.push_back(ent(32'h8));
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_latency got valid=%b busy=%b want valid=0 busy=1", out_valid, busy);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL first_output got valid=%b pc=%h want valid=1 pc=00000000", out_valid, out_pc);
    end
    tick(); tick(); tick();
    out_ready = 1'b0;
    vectors++;
    if (obs_q.size() != 3) begin
      miscompares++;
      $display("FAIL stream_count got %0d want 3", obs_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL stream_entry got pc=%h instr=%h want pc=%h instr=%h", o[63:32], o[31:0], e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    exp_q.push_back(ent(32'h0)); exp_q.push_back(ent(32'h4));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i >= 2) begin
        vectors++;
        if (imem_pc !== 32'h8 || out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== mem_word(32'h0)) begin
          miscompares++;
          $display("FAIL stall_hold cycle %0d got pc=%h valid=%b opc=%h instr=%h want pc=00000008 valid=1 opc=00000000",
                   i, imem_pc, out_valid, out_pc, out_instr);
        end
      end
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (out_pc !== 32'h4 || imem_pc !== 32'hC) begin
      miscompares++;
      $display("FAIL release_next got opc=%h pc=%h want opc=00000004 pc=0000000c", out_pc, imem_pc);
    end
    tick();
    out_ready = 1'b0;
    vectors++;
    if (obs_q.size() != 2) begin
      miscompares++;
      $display("FAIL release_count got %0d want 2", obs_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL release_entry got pc=%h instr=%h want pc=%h instr=%h", o[63:32], o[31:0], e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
    exp_q.push_back(ent(32'h40));
    tick();
    redirect_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || imem_pc !== 32'h40 || obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL redirect_flush got valid=%b pc=%h pops=%0d want valid=0 pc=00000040 pops=0",
               out_valid, imem_pc, obs_q.size());
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40) begin
      miscompares++;
      $display("FAIL redirect_target got valid=%b opc=%h want valid=1 opc=00000040", out_valid, out_pc);
    end
    tick();
    out_ready = 1'b0;
    vectors++;
    if (obs_q.size() != 1) begin
      miscompares++;
      $display("FAIL redirect_count got %0d want 1", obs_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL redirect_entry got pc=%h instr=%h want pc=%h instr=%h", o[63:32], o[31:0], e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    halt_en = 1'b1; halt_addr = 32'hC; out_ready = 1'b1;
    for (int a = 0; a <= 12; a += 4) exp_q.push_back(ent(a));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    vectors++;
    if (halted !== 1'b1 || busy !== 1'b0 || imem_pc !== 32'h10 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_state got halted=%b busy=%b pc=%h valid=%b want halted=1 busy=0 pc=00000010 valid=0",
               halted, busy, imem_pc, out_valid);
    end
    tick(); tick();
    vectors++;
    if (imem_pc !== 32'h10 || halted !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_hold got pc=%h halted=%b want pc=00000010 halted=1", imem_pc, halted);
    end
    vectors++;
    if (obs_q.size() != 4) begin
      miscompares++;
      $display("FAIL halt_count got %0d want 4", obs_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL halt_entry got pc=%h instr=%h want pc=%h instr=%h", o[63:32], o[31:0], e[63:32], e[31:0]);
      end
    end
    exp_q.delete(); obs_q.delete();
    exp_q.push_back(ent(32'h0));
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1 || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_restart got busy=%b halted=%b want busy=1 halted=0", busy, halted);
    end
    tick(); tick();
    out_ready = 1'b0;
    vectors++;
    if (obs_q.size() == 0 || obs_q[0] !== exp_q[0]) begin
      miscompares++;
      $display("FAIL restart_entry got n=%0d want first pc=00000000", obs_q.size());
    end
    halt_en = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back(ent(32'hFFFF_FFFC)); exp_q.push_back(ent(32'h0));
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1 || imem_pc !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL idle_redirect got busy=%b pc=%h want busy=1 pc=fffffffc", busy, imem_pc);
    end
    tick(); tick();
    vectors++;
    if (imem_pc !== 32'h4) begin
      miscompares++;
      $display("FAIL pc_wrap got pc=%h want 00000004", imem_pc);
    end
    tick();
    out_ready = 1'b0;
    vectors++;
    if (obs_q.size() != 2) begin
      miscompares++;
      $display("FAIL wrap_count got %0d want 2", obs_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL wrap_entry got pc=%h instr=%h want pc=%h instr=%h", o[63:32], o[31:0], e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_misalign();
    do_reset();
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
`ifdef IMEM_MISALIGN_TRAP_EN
    vectors++;
    if (fault !== 1'b1 || halted !== 1'b1 || imem_pc !== 32'h4 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_trap got fault=%b halted=%b pc=%h valid=%b want fault=1 halted=1 pc=00000004 valid=0",
               fault, halted, imem_pc, out_valid);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    vectors++;
    if (fault !== 1'b1 || busy !== 1'b1 || imem_pc !== 32'h40) begin
      miscompares++;
      $display("FAIL fault_sticky got fault=%b busy=%b pc=%h want fault=1 busy=1 pc=00000040", fault, busy, imem_pc);
    end
`else
    vectors++;
    if (fault !== 1'b0 || busy !== 1'b1 || imem_pc !== 32'h40) begin
      miscompares++;
      $display("FAIL misalign_force got fault=%b busy=%b pc=%h want fault=0 busy=1 pc=00000040", fault, busy, imem_pc);
    end
`endif
    exp_q.push_back(ent(32'h40));
    tick(); tick();
    out_ready = 1'b0;
    vectors++;
    if (obs_q.size() != 1) begin
      miscompares++;
      $display("FAIL misalign_count got %0d want 1", obs_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL misalign_entry got pc=%h instr=%h want pc=%h instr=%h", o[63:32], o[31:0], e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || imem_pc !== 32'h0 || busy !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset got valid=%b pc=%h busy=%b opc=%h instr=%h want all zero",
               out_valid, imem_pc, busy, out_pc, out_instr);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_halt();
    test_wrap();
    test_misalign();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
